// File: rtl/dz_pkg.sv
// Shared constants, display config record and row-select helper for the dot-matrix scan driver.
// Pure definitions: no latency, no flow control.
package dz_pkg;

  localparam int DZ_ROWS = 8;
  localparam int DZ_COLS = 8;

  localparam logic [1:0] COLOR_OFF   = 2'd0;
  localparam logic [1:0] COLOR_RED   = 2'd1;
  localparam logic [1:0] COLOR_GREEN = 2'd2;
  localparam logic [1:0] COLOR_YEL   = 2'd3;

  localparam logic [3:0] NUM_BLANK = 4'hF;

  typedef struct packed {
    logic [3:0] num;
    logic [1:0] color;
    logic       blink;
  } disp_cfg_t;

  localparam disp_cfg_t CFG_RST = '{num: NUM_BLANK, color: COLOR_OFF, blink: 1'b0};

  function automatic logic [DZ_ROWS-1:0] row_sel(input logic [2:0] idx, input logic active_low);
    logic [DZ_ROWS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/dz_glyph_rom.sv
// Digit glyph ROM: (num, row) -> 8 column bits, bit 7 leftmost; blank for num >= 10.
// Combinational, no latency, no flow control.
module dz_glyph_rom
  import dz_pkg::*;
(
  input  logic [3:0]         num,
  input  logic [2:0]         row,
  output logic [DZ_COLS-1:0] bits
);

  logic [63:0] glyph;
  logic [63:0] shifted;

  // Row 0 lives in the most significant byte of each glyph word.
  always_comb begin
    case (num)
      4'd0:    glyph = 64'h003C666E7666663C;
      4'd1:    glyph = 64'h001838181818187E;
      4'd2:    glyph = 64'h003C66060C30607E;
      4'd3:    glyph = 64'h003C66061C06663C;
      4'd4:    glyph = 64'h000C1C2C4C7E0C0C;
      4'd5:    glyph = 64'h007E607C0606663C;
      4'd6:    glyph = 64'h003C607C6666663C;
      4'd7:    glyph = 64'h007E060C18303030;
      4'd8:    glyph = 64'h003C66663C66663C;
      4'd9:    glyph = 64'h003C66663E060C38;
      default: glyph = 64'h0;
    endcase
    shifted = glyph << {row, 3'b000};
    bits    = shifted[63:56];
  end

endmodule

// File: rtl/dz_scan_ctrl.sv
// 8x8 red/green digit scan driver: prescaled row scan, frame-synchronous digit/colour/blink update.
// Outputs registered, 1 cycle after each row tick; no backpressure, upd is a fire-and-forget strobe.
module dz_scan_ctrl
  import dz_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter int BLINK_FRAMES   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         num,
  input  logic [1:0]         color,
  input  logic               blink,
  input  logic               upd,
  output logic [DZ_ROWS-1:0] row,
  output logic [DZ_COLS-1:0] colr,
  output logic [DZ_COLS-1:0] colg,
  output logic               frame_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0]   DIV_MAX  = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0]   BLK_MAX  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [DZ_ROWS-1:0] ROW_IDLE = {DZ_ROWS{ROW_ACTIVE_LOW}};

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [2:0]         row_idx_q, row_idx_d;
  disp_cfg_t          pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  disp_cfg_t          act_q, act_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [DZ_ROWS-1:0] row_q, row_d;
  logic [DZ_COLS-1:0] colr_q, colr_d;
  logic [DZ_COLS-1:0] colg_q, colg_d;
  logic               frame_done_q, frame_done_d;

  logic               tick;
  logic               boundary;
  logic               red_on;
  logic               grn_on;
  logic               dark;
  disp_cfg_t          in_cfg;
  logic [DZ_COLS-1:0] glyph;

  // Looks up the row about to be shown, using the config that takes effect this tick.
  dz_glyph_rom u_rom (
    .num  (act_d.num),
    .row  (row_idx_d),
    .bits (glyph)
  );

  always_comb begin
    tick      = (div_cnt_q == DIV_MAX);
    boundary  = tick && (row_idx_q == 3'd7);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    row_idx_d = tick ? row_idx_q + 3'd1 : row_idx_q;
    in_cfg    = {num, color, blink};

    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    act_d      = act_q;
    // A strobe landing on the boundary itself bypasses the shadow and shows from row 0.
    if (boundary) begin
      if (upd) begin
        act_d = in_cfg;
      end else if (pend_vld_q) begin
        act_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (upd) begin
      pend_d     = in_cfg;
      pend_vld_d = 1'b1;
    end

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (boundary) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    red_on = (act_d.color == COLOR_RED) || (act_d.color == COLOR_YEL);
    grn_on = (act_d.color == COLOR_GREEN) || (act_d.color == COLOR_YEL);
    dark   = act_d.blink && phase_d;

    row_d        = row_q;
    colr_d       = colr_q;
    colg_d       = colg_q;
    frame_done_d = 1'b0;
    if (tick) begin
      row_d        = row_sel(row_idx_d, ROW_ACTIVE_LOW);
      colr_d       = (red_on && !dark) ? glyph : '0;
      colg_d       = (grn_on && !dark) ? glyph : '0;
      frame_done_d = boundary;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      row_idx_q    <= 3'd7;
      pend_q       <= CFG_RST;
      pend_vld_q   <= 1'b0;
      act_q        <= CFG_RST;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      row_q        <= ROW_IDLE;
      colr_q       <= '0;
      colg_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      row_idx_q    <= row_idx_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      act_q        <= act_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      row_q        <= row_d;
      colr_q       <= colr_d;
      colg_q       <= colg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row        = row_q;
  assign colr       = colr_q;
  assign colg       = colg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// Scoreboard bench for dz_scan_ctrl: expected row slots queued up front, a monitor pops one per new row.
`timescale 1ns/1ps
module tb_dz_scan_ctrl;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] num   = 4'd0;
  logic [1:0] color = 2'd0;
  logic       blink = 1'b0;
  logic       upd   = 1'b0;
  logic [7:0] row, colr, colg;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  dz_scan_ctrl #(
    .SCAN_DIV       (4),
    .ROW_ACTIVE_LOW (1'b1),
    .BLINK_FRAMES   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .num        (num),
    .color      (color),
    .blink      (blink),
    .upd        (upd),
    .row        (row),
    .colr       (colr),
    .colg       (colg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input int n, input int r);
    logic [63:0] g;
    case (n)
      3:       g = 64'h003C66061C06663C;
      4:       g = 64'h000C1C2C4C7E0C0C;
      5:       g = 64'h007E607C0606663C;
      default: g = 64'h0;
    endcase
    g = g << (8 * r);
    return g[63:56];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input int n, input bit r_on, input bit g_on, input int nrows);
    exp_t e;
    for (int r = 0; r < nrows; r++) begin
      e.row  = ~(8'h01 << r);
      e.colr = r_on ? glyph(n, r) : 8'h00;
      e.colg = g_on ? glyph(n, r) : 8'h00;
      e.fd   = (r == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int p);
    while (cyc < p) step();
  endtask

  // Holds upd high for the cycle that ends at posedge p.
  task automatic do_upd(input int p, input logic [3:0] n, input logic [1:0] c, input logic b);
    run_to(p - 1);
    num   = n;
    color = c;
    blink = b;
    upd   = 1'b1;
    step();
    upd   = 1'b0;
  endtask

  initial begin
    logic [7:0] prev_row;
    exp_t       e;
    prev_row = 8'hFF;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (row != prev_row && row != 8'hFF) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_slot: row %h colr %h colg %h with empty queue", row, colr, colg);
          end else begin
            e = exp_q.pop_front();
            check("slot_row", row, e.row);
            check("slot_colr", colr, e.colr);
            check("slot_colg", colg, e.colg);
            check("slot_frame_done", frame_done, e.fd);
          end
        end else begin
          check("idle_frame_done", frame_done, 0);
        end
      end
      prev_row = row;
    end
  end

  initial begin
    push_frame(15, 0, 0, 8);  // f1: blank, upd mid-frame not yet visible
    push_frame(5, 1, 0, 8);   // f2: 5 red
    push_frame(4, 1, 1, 8);   // f3: 4 yellow
    push_frame(4, 0, 1, 8);   // f4: 4 green
    push_frame(3, 1, 0, 8);   // f5: blink phase 0
    push_frame(3, 0, 0, 8);   // f6: dark
    push_frame(3, 0, 0, 8);   // f7: dark
    push_frame(3, 1, 0, 8);   // f8
    push_frame(3, 1, 0, 8);   // f9
    push_frame(3, 1, 0, 8);   // f10: blink cleared, would be dark otherwise
    push_frame(3, 0, 1, 8);   // f11: last of two upds wins
    push_frame(4, 1, 0, 3);   // f12: boundary upd, reset during row 2
    push_frame(15, 0, 0, 8);  // after reset: blank
    push_frame(15, 0, 0, 8);

    repeat (3) @(posedge clk);
    #1;
    check("rst_row", row, 8'hFF);
    check("rst_colr", colr, 8'h00);
    check("rst_colg", colg, 8'h00);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    cyc = 0;
    run_to(3);
    check("pre_tick_row", row, 8'hFF);
    step();
    check("first_tick_row", row, 8'hFE);

    do_upd(16, 4'd5, 2'd1, 1'b0);
    do_upd(48, 4'd4, 2'd3, 1'b0);
    do_upd(80, 4'd4, 2'd2, 1'b0);
    do_upd(112, 4'd3, 2'd1, 1'b1);
    do_upd(272, 4'd3, 2'd1, 1'b0);
    do_upd(300, 4'd5, 2'd1, 1'b0);
    do_upd(310, 4'd3, 2'd2, 1'b0);
    do_upd(356, 4'd4, 2'd1, 1'b0);

    run_to(365);
    check("pre_rst_row", row, 8'hFB);
    rst = 1'b1;
    #1;
    check("async_rst_row", row, 8'hFF);
    check("async_rst_colr", colr, 8'h00);
    check("async_rst_colg", colg, 8'h00);
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    run_to(3);
    check("restart_pre_tick_row", row, 8'hFF);
    step();
    check("restart_first_tick_row", row, 8'hFE);
    run_to(66);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
